// File: rtl/imem_loader.sv
// Program loader: turns a little-endian byte stream into 32-bit words written to instruction memory.
// Latency: one count byte, then 4 accept cycles + 1 WRITE cycle per word; DONE pulses one cycle later.
// Backpressure: in_ready (registered) is low outside RECV_* states; a waiting byte is held, never dropped.
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_loader #(
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV_COUNT,
    S_RECV_WORD,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_RECV_CSUM
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [ADDR_W:0] nwords;
  logic [ADDR_W:0] widx;
  logic [ADDR_W:0] widx_inc;
  logic [1:0]      bidx;
  logic [31:0]     wdata;
  logic [TW-1:0]   tcnt;
  logic            accept;
  logic            start_ok;
  logic            count_bad;
  logic            tout;
  logic            last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      sum;
  logic [7:0]      sum_nxt;
`endif

  // States in which a byte may be accepted (and the idle timer runs).
  function automatic logic is_recv(input state_t s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    return (s == S_RECV_COUNT) || (s == S_RECV_WORD) || (s == S_RECV_CSUM);
`else
    return (s == S_RECV_COUNT) || (s == S_RECV_WORD);
`endif
  endfunction

  assign accept    = in_valid && in_ready;
  assign start_ok  = load_start && ((state == S_IDLE) || (state == S_ERROR));
  assign count_bad = (in_data == 8'd0) || (32'(in_data) > DEPTH);
  // An accepted byte on the expiry edge wins over the timeout.
  assign tout      = (tcnt == TW'(TIMEOUT - 1)) && !accept;
  assign widx_inc  = widx + 1'b1;
  assign last_word = (widx_inc == nwords);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign sum_nxt   = sum + in_data;
`endif

  // Word index doubles as the write address (low bits) and the loaded-word count (full width).
  assign mem_waddr    = widx[ADDR_W-1:0];
  assign words_loaded = widx;
  assign mem_wdata    = wdata;

  // Next-state decode and per-state output strobes.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    cpu_hold  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_start) state_nxt = S_RECV_COUNT;
      end
      S_ERROR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
        if (load_start) state_nxt = S_RECV_COUNT;
      end
      S_RECV_COUNT: begin
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (accept)    state_nxt = count_bad ? S_ERROR : S_RECV_WORD;
        else if (tout) state_nxt = S_ERROR;
      end
      S_RECV_WORD: begin
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if (bidx == 2'd3) state_nxt = S_WRITE;
        end else if (tout) begin
          state_nxt = S_ERROR;
        end
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (!last_word) state_nxt = S_RECV_WORD;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else            state_nxt = S_RECV_CSUM;
`else
        else            state_nxt = S_DONE;
`endif
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_hold  = 1'b1;
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_RECV_CSUM: begin
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (accept)    state_nxt = (sum_nxt == 8'd0) ? S_DONE : S_ERROR;
        else if (tout) state_nxt = S_ERROR;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, registered in_ready, word/byte indices, word assembly and idle timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      nwords   <= '0;
      widx     <= '0;
      bidx     <= '0;
      wdata    <= '0;
      tcnt     <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= is_recv(state_nxt);
      if (start_ok) begin
        widx <= '0;
        bidx <= '0;
        tcnt <= '0;
      end else begin
        if (is_recv(state)) tcnt <= accept ? '0 : tcnt + 1'b1;
        if (accept && (state == S_RECV_COUNT)) nwords <= (ADDR_W+1)'(in_data);
        if (accept && (state == S_RECV_WORD)) begin
          wdata[8*bidx +: 8] <= in_data;
          bidx               <= bidx + 2'd1;
        end
        if (state == S_WRITE) widx <= widx_inc;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running mod-256 sum of the count byte and every data byte of the current load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sum <= '0;
    else if (start_ok) sum <= '0;
    else if (accept)   sum <= sum_nxt;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (TIMEOUT shortened to 16 cycles).
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Write/done activity is logged by a monitor and compared against hand-computed values.
module tb_imem_loader;
  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  words_loaded;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [6:0]  we_addr_q[$];
  logic [31:0] we_data_q[$];

  imem_loader #(.DEPTH(128), .ADDR_W(7), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Log every memory write and done pulse.
  always @(negedge clk) begin
    if (mem_we) begin
      we_addr_q.push_back(mem_waddr);
      we_data_q.push_back(mem_wdata);
    end
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {in_ready, mem_we, cpu_hold, busy, done, error}
  function automatic logic [5:0] status();
    return {in_ready, mem_we, cpu_hold, busy, done, error};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Called at a falling edge; returns at the falling edge just after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_bound", 32'(n < 40), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  localparam logic [5:0] ST_IDLE = 6'b000000;
  localparam logic [5:0] ST_RECV = 6'b101100;
  localparam logic [5:0] ST_WR   = 6'b011100;
  localparam logic [5:0] ST_DONE = 6'b001110;
  localparam logic [5:0] ST_ERR  = 6'b001001;

  logic [7:0]  s4 [$];
  logic [31:0] w4 [3];
  int          gap [14];
  int          base;
  int          dbase;

  initial begin
    rst_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_status", 32'(status()), 32'(ST_IDLE));
    chk("reset_waddr", 32'(mem_waddr), 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    chk("reset_words", 32'(words_loaded), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of word 0, before the write.
    base = we_addr_q.size();
    start_load();
    chk("t1_recv_count", 32'(status()), 32'(ST_RECV));
    send_byte(8'h02);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("t1_partial_word", mem_wdata, 32'h0000_0013);
    in_valid = 1'b1; in_data = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_status", 32'(status()), 32'(ST_IDLE));
    chk("t1_async_wdata", mem_wdata, 32'd0);
    chk("t1_async_words", 32'(words_loaded), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_idle_after", 32'(status()), 32'(ST_IDLE));
    chk("t1_no_write", 32'(we_addr_q.size() - base), 32'd0);

    // Nominal two-word load, next word presented during WRITE.
    base = we_addr_q.size(); dbase = done_cnt;
    start_load();
    send_byte(8'h02);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("t2_write0_status", 32'(status()), 32'(ST_WR));
    chk("t2_write0_addr", 32'(mem_waddr), 32'd0);
    chk("t2_write0_data", mem_wdata, 32'h0000_0013);
    send_byte(8'hB3); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h38);
`else
    @(negedge clk);
`endif
    chk("t2_done_status", 32'(status()), 32'(ST_DONE));
    @(negedge clk);
    chk("t2_idle_after", 32'(status()), 32'(ST_IDLE));
    chk("t2_words", 32'(words_loaded), 32'd2);
    chk("t2_we_count", 32'(we_addr_q.size() - base), 32'd2);
    chk("t2_done_count", 32'(done_cnt - dbase), 32'd1);
    if (we_addr_q.size() - base == 2) begin
      chk("t2_addr1", 32'(we_addr_q[base+1]), 32'd1);
      chk("t2_data1", we_data_q[base+1], 32'h0000_00B3);
    end

    // Bad counts: 0x00 and 0x81 both end in ERROR; restart clears error and count.
    base = we_addr_q.size();
    start_load();
    send_byte(8'h00);
    chk("t3_zero_err", 32'(status()), 32'(ST_ERR));
    start_load();
    chk("t3_restart_status", 32'(status()), 32'(ST_RECV));
    chk("t3_restart_words", 32'(words_loaded), 32'd0);
    send_byte(8'h81);
    chk("t3_big_err", 32'(status()), 32'(ST_ERR));
    start_load();
    chk("t3_err_cleared", 32'(status()), 32'(ST_RECV));
    chk("t3_no_write", 32'(we_addr_q.size() - base), 32'd0);

    // Three words with idle gaps (up to the 15-cycle limit) and a load_start while busy.
    base = we_addr_q.size(); dbase = done_cnt;
    s4 = '{8'h03, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12,
           8'h01, 8'h00, 8'h00, 8'hA5};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s4.push_back(8'h0B);
`endif
    w4  = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hA500_0001};
    gap = '{0, 3, 15, 1, 0, 7, 2, 0, 15, 5, 0, 1, 0, 4};
    for (int i = 0; i < s4.size(); i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        load_start = (i == 6) && (g == 0);
        @(negedge clk);
      end
      load_start = 1'b0;
      send_byte(s4[i]);
    end
    repeat (3) @(negedge clk);
    chk("t4_idle_after", 32'(status()), 32'(ST_IDLE));
    chk("t4_words", 32'(words_loaded), 32'd3);
    chk("t4_done_count", 32'(done_cnt - dbase), 32'd1);
    chk("t4_we_count", 32'(we_addr_q.size() - base), 32'd3);
    if (we_addr_q.size() - base == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("t4_addr%0d", k), 32'(we_addr_q[base+k]), k);
        chk($sformatf("t4_data%0d", k), we_data_q[base+k], w4[k]);
      end
    end

    // Timeout: stream stops after 2 bytes of word 0.
    base = we_addr_q.size();
    start_load();
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (15) @(negedge clk);
    chk("t5_alive_at_15", 32'(status()), 32'(ST_RECV));
    @(negedge clk);
    chk("t5_err_at_16", 32'(status()), 32'(ST_ERR));
    chk("t5_no_write", 32'(we_addr_q.size() - base), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: ERROR, no done, both words still written.
    base = we_addr_q.size(); dbase = done_cnt;
    start_load();
    send_byte(8'h02);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hB3); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h39);
    chk("t6_csum_err", 32'(status()), 32'(ST_ERR));
    chk("t6_no_done", 32'(done_cnt - dbase), 32'd0);
    chk("t6_we_count", 32'(we_addr_q.size() - base), 32'd2);
    chk("t6_words", 32'(words_loaded), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program-load controller for the 128-word instruction memory. It takes a byte stream from a UART receiver or debug bridge over a valid/ready handshake and assembles the bytes into 32-bit little-endian words. It sequences single-cycle writes into the instruction memory write port and holds the CPU stalled while loading. It sits between the host byte source, the instruction memory and the core's stall/reset logic.

Parameters:
DEPTH, 128, number of instruction words; also the maximum accepted word count.
ADDR_W, 7, width of the word address (log2 DEPTH).
TIMEOUT, 100000, maximum idle cycles allowed between accepted bytes while loading.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
load_start  input  1  single-cycle request to begin a load; honoured only in IDLE or ERROR.
in_valid  input  1  byte source has a byte on in_data.
in_data  input  8  stream byte.
in_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
mem_waddr  output  ADDR_W  word address for the write.
mem_wdata  output  32  assembled word.
cpu_hold  output  1  stalls the core; high while loading or in error.
busy  output  1  high in any state except IDLE and ERROR.
done  output  1  one-cycle pulse on successful completion.
error  output  1  sticky error flag.
words_loaded  output  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready, mem_we, cpu_hold, busy, done and error are all 0.
  - mem_waddr, mem_wdata and words_loaded are 0.
  - Reset mid-load aborts immediately; memory contents already written are left as they are.
- Handshake: a byte transfers on a rising edge with in_valid && in_ready. in_ready is a registered output, asserted only in RECV_COUNT, RECV_WORD and RECV_CSUM.
- IDLE:
  - cpu_hold=0.
  - load_start=1 moves to RECV_COUNT. In the same edge: clear error and words_loaded, clear the byte index, word index and timeout counter.
- RECV_COUNT:
  - Accept one byte N = number of words.
  - N==0 or N>DEPTH goes to ERROR.
  - Otherwise latch N and go to RECV_WORD.
- RECV_WORD:
  - Accept 4 bytes. Byte k (k=0..3) goes into wdata[8k+7:8k].
  - After the 4th byte, go to WRITE.
- WRITE (exactly 1 cycle):
  - mem_we=1, mem_waddr=word index, mem_wdata=assembled word; in_ready=0.
  - Next edge: word index+1, words_loaded+1.
  - If the word just written was word N-1, go to RECV_CSUM when the checksum feature is enabled, otherwise to DONE. Else return to RECV_WORD.
- DONE (1 cycle):
  - done=1, cpu_hold=1.
  - Then go to IDLE, where cpu_hold drops.
- ERROR:
  - error=1, cpu_hold=1, busy=0, in_ready=0.
  - Stays in ERROR until load_start, which behaves as it does in IDLE.
- cpu_hold and busy timing:
  - cpu_hold=1 from the cycle after load_start is accepted through the DONE cycle inclusive.
  - busy has the same span as cpu_hold but excludes ERROR.
- Timeout:
  - The counter runs in the RECV_* states and resets on every accepted byte.
  - Reaching TIMEOUT goes to ERROR. A byte accepted on the same edge as the timeout wins: no error, and the counter clears.
- Simultaneous events: load_start while busy is ignored. in_valid while in_ready=0 is left pending and never dropped.
- Address width: the word index is ADDR_W+1 bits wide, so N=128 does not wrap. mem_waddr carries the low ADDR_W bits.
- Latency: a full word takes a minimum of 5 cycles (4 accept cycles + 1 WRITE).

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- Defined:
  - An 8-bit running sum mod 256 covers the count byte and all data bytes.
  - After the last WRITE, the loader enters RECV_CSUM and accepts one more byte C.
  - If (sum + C) mod 256 == 0, go to DONE; otherwise go to ERROR. Memory keeps the words already written.
- Undefined: no RECV_CSUM state and no sum register. The loader goes straight from the last WRITE to DONE.

Test Plan:
- Reset mid-stream:
  - Stimulus: load_start, byte 0x02, then bytes 13 00 00 00 of word 0; assert rst_n=0 before the write.
  - Required: all outputs 0 asynchronously; mem_we never pulsed; state IDLE after release.
- Nominal load:
  - Stimulus: load_start, then bytes 02, 13 00 00 00, B3 00 00 00 (plus checksum 38 if enabled).
  - Required: mem_we pulses at addr 0 with 0x00000013 and at addr 1 with 0x000000B3; words_loaded=2; one done pulse; cpu_hold=0 afterwards.
- Bad count:
  - Stimulus: count byte 0x00, then separately count byte 0x81.
  - Required: ERROR in both cases; error=1, cpu_hold=1, no mem_we. A following load_start clears error.
- Backpressure and stalls:
  - Stimulus: in_valid held high throughout WRITE; random in_valid gaps shorter than TIMEOUT.
  - Required: no byte lost or duplicated; word contents correct.
- Timeout:
  - Stimulus: TIMEOUT=16; stop the stream after 2 bytes of word 0.
  - Required: ERROR after 16 idle cycles. A byte arriving on the 16th cycle instead keeps the load alive.
- Checksum (feature enabled):
  - Stimulus: nominal stream with checksum 0x39 instead of 0x38.
  - Required: ERROR; done never pulses; both words remain written.
